youxianji_arbiter: RTL and testbench
====================================

Name: youxianji_arbiter

Overview:
- Sequential 8-requester arbiter that shares one resource among requesters REQ[0..7].
- Supports two modes:
  - fixed priority: index 0 highest, index 7 lowest.
  - round-robin: search starts at a rotating pointer.
- Drives a registered one-hot grant plus a binary grant index, holds the grant until release or hold-limit timeout, and inserts one dead cycle between grants.
- Sits between the requester ports and the shared resource's select mux.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 = no limit; legal range 0..255.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  active-high disable. 1 = no arbitration and any current grant is revoked; 0 = normal operation.
- RR_EN  input  1  1 = round-robin mode, 0 = fixed-priority mode.
- REQ  input  8  request vector, level-sensitive; REQ[i] is held high for as long as requester i wants the resource.
- GNT  output  8  one-hot grant, registered; all zero when no grant.
- GNT_ID  output  3  binary index of the current or most recent grant, registered.
- BUSY  output  1  high while in GRANT state.
- TIMEOUT  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- One clock, CLK. RST_N is asynchronous, active-low; its deassertion is synchronised to CLK.
- Reset values: state IDLE, GNT=8'h00, GNT_ID=3'b000, BUSY=0, TIMEOUT=0, round-robin pointer PTR=3'b000, hold counter HCNT=8'd0.
- Reset mid-grant: GNT drops immediately (asynchronous); PTR returns to 0.
- States: IDLE, GRANT, GAP.

Arbitration (evaluated in IDLE and GAP only):
- Only when EN=0 and REQ != 0.
- Fixed mode: winner = lowest set index of REQ.
- RR mode: winner = first set bit found scanning PTR, PTR+1, ..., PTR+7 mod 8 (wrap 7->0).
- On the same edge: GNT <= onehot(winner), GNT_ID <= winner, HCNT <= 0, state -> GRANT, BUSY <= 1.
- Latency: REQ sampled at edge k produces GNT visible after edge k, i.e. 1 cycle.
- No winner: stay in the current state; from GAP go to IDLE. GNT stays 0; GNT_ID retains its last value.

GRANT (HCNT increments each cycle; saturates at 255):
- Release: REQ[GNT_ID]=0 sampled -> GNT<=0, BUSY<=0, state -> GAP. In RR mode, PTR <= GNT_ID+1 mod 8.
- Timeout: MAX_HOLD != 0, HCNT == MAX_HOLD-1 and REQ[GNT_ID] still 1 -> same as release, plus TIMEOUT<=1 for one cycle.
  - Total hold is exactly MAX_HOLD cycles.
  - The revoked requester may win again later under normal rules.
- EN=1 sampled -> GNT<=0, BUSY<=0, state -> IDLE. PTR is unchanged; TIMEOUT is not pulsed.

GAP:
- GNT=0 for exactly one cycle.
- Arbitration is performed during GAP using the updated PTR, so back-to-back grants have one idle cycle between them.

Simultaneous events:
- Release and timeout on the same edge: treated as release; no TIMEOUT.
- EN=1 together with release or timeout: EN wins; go to IDLE, no PTR update, no TIMEOUT.
- REQ bits other than GNT_ID changing during GRANT: ignored.

Mode changes:
- RR_EN changes take effect at the next arbitration.
- PTR is updated only in RR mode.

Invariants:
- GNT is always one-hot or zero.
- GNT != 0 exactly when BUSY = 1.
- When BUSY = 1, GNT_ID equals the index of the set GNT bit.

Test Plan:
- Reset then fixed mode: RR_EN=0, REQ=8'b1010_0100 held.
  - Edge after sampling: GNT=8'h04, GNT_ID=2.
  - Drop REQ[2]: GNT=0 for 1 cycle, then GNT=8'h20, GNT_ID=5.
- RR rotation with MAX_HOLD=0: RR_EN=1, REQ=8'hFF.
  - Each requester releases after 2 cycles and re-requests at once.
  - Grant order is 0,1,2,...,7,0, with one GAP cycle between grants.
- Wrap-around: PTR=7 (after a grant to index 6 releases), REQ=8'b0000_0011.
  - Grant goes to index 0; after release PTR=1.
- Timeout: MAX_HOLD=4, REQ[3] held high continuously.
  - GNT=8'h08 for exactly 4 cycles, TIMEOUT high for 1 cycle, 1 GAP cycle.
  - In fixed mode, index 3 is re-granted.
- EN abort: EN rises during a grant to index 5.
  - GNT=0 on the next edge, state IDLE, no TIMEOUT, PTR unchanged.
  - While EN=1 with REQ=8'hFF, GNT stays 0.
- Async reset mid-grant: pull RST_N low between clock edges.
  - GNT=0, BUSY=0 and GNT_ID=0 immediately.
  - After release, the first grant follows fixed/RR rules from PTR=0.

Source files
------------

// File: rtl/youxianji_arbiter_if.sv
// Requester/resource-side bundle for youxianji_arbiter.
// Requesters and control drive EN/RR_EN/REQ; the arbiter drives the grant outputs.
interface youxianji_arbiter_if;
    logic       EN;       // 1 = arbitration disabled, any grant revoked
    logic       RR_EN;    // 1 = round-robin, 0 = fixed priority
    logic [7:0] REQ;      // level-sensitive request vector
    logic [7:0] GNT;      // one-hot grant, all zero when idle
    logic [2:0] GNT_ID;   // index of current or most recent grant
    logic       BUSY;     // high while a grant is held
    logic       TIMEOUT;  // one-cycle pulse on hold-limit revocation

    modport master (
        output EN, RR_EN, REQ,
        input  GNT, GNT_ID, BUSY, TIMEOUT
    );

    modport slave (
        input  EN, RR_EN, REQ,
        output GNT, GNT_ID, BUSY, TIMEOUT
    );
endinterface

// File: rtl/youxianji_arbiter.sv
// youxianji_arbiter: 8-requester arbiter with fixed-priority or round-robin
// selection, registered one-hot grant plus index, optional hold limit and a
// single dead cycle between consecutive grants.
module youxianji_arbiter #(
    parameter int unsigned MAX_HOLD = 16   // 0 = unlimited, otherwise 1..255
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    youxianji_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Last hold-counter value before the limit is reached; unused when MAX_HOLD is 0.
    localparam logic [7:0] LP_HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    // Reset synchroniser: assertion is immediate, release is aligned to CLK.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    state_t     r_state,   w_state_nxt;
    logic [7:0] r_gnt,     w_gnt_nxt;
    logic [2:0] r_gnt_id,  w_gnt_id_nxt;
    logic       r_busy,    w_busy_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic [2:0] r_ptr,     w_ptr_nxt;
    logic [7:0] r_hcnt,    w_hcnt_nxt;

    logic [2:0] w_base;
    logic [2:0] w_scan_idx;
    logic       w_win_vld;
    logic [2:0] w_win_id;
    logic       w_owner_req;
    logic       w_hold_hit;

    // Two-flop reset release synchroniser.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Winner search: scan eight positions starting at PTR (RR) or 0 (fixed).
    always_comb begin
        w_base     = bus.RR_EN ? r_ptr : 3'd0;
        w_scan_idx = '0;
        w_win_vld  = 1'b0;
        w_win_id   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_scan_idx = w_base + 3'(i);
            if (!w_win_vld && bus.REQ[w_scan_idx]) begin
                w_win_vld = 1'b1;
                w_win_id  = w_scan_idx;
            end
        end
    end

    assign w_owner_req = bus.REQ[r_gnt_id];
    assign w_hold_hit  = (MAX_HOLD != 0) && (r_hcnt == LP_HOLD_LAST);

    // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hcnt_nxt    = r_hcnt;

        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (!bus.EN && w_win_vld) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_nxt    = 8'd1 << w_win_id;
                    w_gnt_id_nxt = w_win_id;
                    w_busy_nxt   = 1'b1;
                    w_hcnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end

            ST_GRANT: begin
                if (r_hcnt != 8'hFF) begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end
                // Priority: EN abort, then release, then hold-limit timeout.
                if (bus.EN) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else if (!w_owner_req || w_hold_hit) begin
                    w_state_nxt   = ST_GAP;
                    w_gnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = w_owner_req;
                    if (bus.RR_EN) begin
                        w_ptr_nxt = r_gnt_id + 3'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_hcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hcnt    <= w_hcnt_nxt;
        end
    end

    assign bus.GNT     = r_gnt;
    assign bus.GNT_ID  = r_gnt_id;
    assign bus.BUSY    = r_busy;
    assign bus.TIMEOUT = r_timeout;

endmodule

// File: tb/tb_youxianji_arbiter.sv
// Bench for youxianji_arbiter: three instances (hold limits 4, 0, default 16)
// share one stimulus stream; a behavioural model queues expected outputs and
// a monitor compares them on the falling edge.
module tb_youxianji_arbiter;

    localparam int NDUT = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    always #5 CLK = ~CLK;

    youxianji_arbiter_if bus_a ();
    youxianji_arbiter_if bus_b ();
    youxianji_arbiter_if bus_c ();

    youxianji_arbiter #(.MAX_HOLD(4)) u_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
    youxianji_arbiter #(.MAX_HOLD(0)) u_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));
    youxianji_arbiter                 u_c (.CLK(CLK), .RST_N(RST_N), .bus(bus_c));

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       to;
    } exp_t;
    typedef exp_t [NDUT-1:0] exp3_t;

    exp3_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state per instance.
    int m_owner [NDUT];   // -1 = nobody holds the resource
    int m_held  [NDUT];   // completed cycles of the current grant
    int m_ptr   [NDUT];
    int m_last  [NDUT];
    bit m_to    [NDUT];

    function automatic int hold_of(input int k);
        case (k)
            0:       return 4;
            1:       return 0;
            default: return 16;
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_ptr[k]   = 0;
            m_last[k]  = 0;
            m_to[k]    = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic en, input logic rr, input logic [7:0] req);
        for (int k = 0; k < NDUT; k++) begin
            m_to[k] = 1'b0;
            if (m_owner[k] >= 0) begin
                m_held[k]++;
                if (en) begin
                    m_owner[k] = -1;
                end else if (!req[m_owner[k]]) begin
                    if (rr) m_ptr[k] = (m_owner[k] + 1) % 8;
                    m_owner[k] = -1;
                end else if (hold_of(k) != 0 && m_held[k] >= hold_of(k)) begin
                    if (rr) m_ptr[k] = (m_owner[k] + 1) % 8;
                    m_owner[k] = -1;
                    m_to[k]    = 1'b1;
                end
            end else if (!en && req != 8'h00) begin
                int start;
                bit found;
                start = rr ? m_ptr[k] : 0;
                found = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    int c;
                    c = (start + j) % 8;
                    if (!found && req[c]) begin
                        found      = 1'b1;
                        m_owner[k] = c;
                        m_last[k]  = c;
                        m_held[k]  = 0;
                    end
                end
            end
        end
    endfunction

    function automatic exp3_t model_outputs();
        exp3_t x;
        for (int k = 0; k < NDUT; k++) begin
            x[k].gnt  = (m_owner[k] >= 0) ? 8'(1 << m_owner[k]) : 8'h00;
            x[k].id   = 3'(m_last[k]);
            x[k].busy = (m_owner[k] >= 0);
            x[k].to   = m_to[k];
        end
        return x;
    endfunction

    function automatic void chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", nm, k, act, exp, $time);
        end
    endfunction

    function automatic void cmp_dut(input int k, input logic [7:0] g, input logic [2:0] id,
                                    input logic b, input logic t, input exp_t e);
        chk("GNT",     k, g,          e.gnt);
        chk("GNT_ID",  k, {5'd0, id}, {5'd0, e.id});
        chk("BUSY",    k, {7'd0, b},  {7'd0, e.busy});
        chk("TIMEOUT", k, {7'd0, t},  {7'd0, e.to});
    endfunction

    // Scoreboard monitor: one expectation per clock edge, checked mid-cycle.
    always @(negedge CLK) begin
        exp3_t x;
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            cmp_dut(0, bus_a.GNT, bus_a.GNT_ID, bus_a.BUSY, bus_a.TIMEOUT, x[0]);
            cmp_dut(1, bus_b.GNT, bus_b.GNT_ID, bus_b.BUSY, bus_b.TIMEOUT, x[1]);
            cmp_dut(2, bus_c.GNT, bus_c.GNT_ID, bus_c.BUSY, bus_c.TIMEOUT, x[2]);
        end
    end

    task automatic drive(input logic en, input logic rr, input logic [7:0] req);
        bus_a.EN = en; bus_a.RR_EN = rr; bus_a.REQ = req;
        bus_b.EN = en; bus_b.RR_EN = rr; bus_b.REQ = req;
        bus_c.EN = en; bus_c.RR_EN = rr; bus_c.REQ = req;
    endtask

    // Apply one cycle of inputs and queue the response expected after the next edge.
    task automatic step(input logic en, input logic rr, input logic [7:0] req);
        @(negedge CLK);
        #1;
        drive(en, rr, req);
        model_step(en, rr, req);
        sb_q.push_back(model_outputs());
    endtask

    task automatic check_all_zero();
        exp_t z;
        z = '0;
        cmp_dut(0, bus_a.GNT, bus_a.GNT_ID, bus_a.BUSY, bus_a.TIMEOUT, z);
        cmp_dut(1, bus_b.GNT, bus_b.GNT_ID, bus_b.BUSY, bus_b.TIMEOUT, z);
        cmp_dut(2, bus_c.GNT, bus_c.GNT_ID, bus_c.BUSY, bus_c.TIMEOUT, z);
    endtask

    initial begin
        logic [7:0] req_r;
        logic       rr_r;
        logic [7:0] rq;

        drive(1'b0, 1'b0, 8'h00);
        model_reset();
        #2 RST_N = 1'b0;
        #1 check_all_zero();
        repeat (3) @(negedge CLK);
        #1 RST_N = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'h00);

        // Fixed priority: 2 wins, then 5 after 2 drops.
        repeat (3) step(1'b0, 1'b0, 8'hA4);
        repeat (4) step(1'b0, 1'b0, 8'hA0);
        repeat (2) step(1'b0, 1'b0, 8'h00);

        // Round-robin rotation: each owner drops its request after two cycles.
        for (int c = 0; c < 40; c++) begin
            rq = 8'hFF;
            if (m_owner[1] >= 0 && m_held[1] >= 1) rq[m_owner[1]] = 1'b0;
            step(1'b0, 1'b1, rq);
        end
        repeat (2) step(1'b0, 1'b1, 8'h00);

        // Wrap-around: grant 6, release (PTR=7), then 0 and 1 requesting.
        repeat (3) step(1'b0, 1'b1, 8'h40);
        repeat (2) step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b1, 8'h03);
        repeat (3) step(1'b0, 1'b1, 8'h02);
        repeat (2) step(1'b0, 1'b1, 8'h00);

        // Hold limit: requester 3 held continuously in fixed mode.
        repeat (20) step(1'b0, 1'b0, 8'h08);
        repeat (2) step(1'b0, 1'b0, 8'h00);

        // EN abort during a grant to 5, then EN held with all requesting.
        repeat (3) step(1'b0, 1'b1, 8'h20);
        repeat (4) step(1'b1, 1'b1, 8'hFF);
        repeat (3) step(1'b0, 1'b1, 8'h60);
        repeat (2) step(1'b0, 1'b1, 8'h00);

        // Async reset mid-grant with PTR moved away from 0 beforehand.
        repeat (3) step(1'b0, 1'b1, 8'h10);
        repeat (2) step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b1, 8'h10);
        @(negedge CLK);
        #1 RST_N = 1'b0;
        #1 check_all_zero();
        model_reset();
        drive(1'b0, 1'b1, 8'h00);
        #1 RST_N = 1'b1;
        repeat (3) step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b1, 8'h81);
        repeat (2) step(1'b0, 1'b1, 8'h00);

        // Randomised traffic with sticky requests and occasional EN/mode flips.
        req_r = 8'h00;
        rr_r  = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            req_r = req_r ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 31) == 0) rr_r = ~rr_r;
            step(($urandom_range(0, 15) == 0), rr_r, req_r);
        end

        repeat (2) @(negedge CLK);
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d required=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
